// File: rtl/cache_mem_responder.sv
// Cache line memory responder.
// Turns 128-bit cache line requests into 32-bit backing-SRAM beats.
// Writes are posted through a one-entry pending buffer and drained as four
// write beats. Reads are served as four read beats plus one tail cycle to
// collect the last SRAM word, followed by a one-cycle ready response.
// Every SRAM-side output and the response are driven straight from flops.

package cache_mem_pkg;

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
        logic         rw;
        logic         valid;
    } mem_req_type;

    typedef struct packed {
        logic [127:0] data;
        logic         ready;
    } mem_data_type;

endpackage

module cache_mem_responder
    import cache_mem_pkg::*;
#(
    parameter int MEM_AW = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  mem_req_type       mem_req_i,
    output mem_data_type      mem_data_o,
    output logic              sram_en_o,
    output logic              sram_we_o,
    output logic [MEM_AW-1:0] sram_addr_o,
    output logic [31:0]       sram_wdata_o,
    input  logic [31:0]       sram_rdata_i,
    output logic              busy_o,
    output logic              overflow_o
);

    // Only the line-address bits that reach the SRAM word address are kept.
    localparam int LW = MEM_AW - 2;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WRITE     = 3'd1;
    localparam logic [2:0] ST_READ      = 3'd2;
    localparam logic [2:0] ST_READ_TAIL = 3'd3;
    localparam logic [2:0] ST_RESP      = 3'd4;

    // Selects 32-bit word k of a 128-bit line.
    function automatic logic [31:0] beat_word(input logic [127:0] line,
                                              input logic [1:0]   k);
        logic [31:0] w;
        case (k)
            2'd0:    w = line[31:0];
            2'd1:    w = line[63:32];
            2'd2:    w = line[95:64];
            2'd3:    w = line[127:96];
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    // Registered state.
    logic [2:0]        state_r;
    logic [1:0]        beat_r;
    logic [LW-1:0]     work_line_r;
    logic [127:0]      work_data_r;
    logic              pend_valid_r;
    logic [LW-1:0]     pend_line_r;
    logic [127:0]      pend_data_r;
    logic              overflow_r;
    logic              busy_r;
    logic              sram_en_r;
    logic              sram_we_r;
    logic [MEM_AW-1:0] sram_addr_r;
    logic [31:0]       sram_wdata_r;
    logic [95:0]       rd_buf_r;
    logic [127:0]      resp_data_r;
    logic              resp_ready_r;

    // Next-state values.
    logic [2:0]        state_s;
    logic [1:0]        beat_s;
    logic [LW-1:0]     work_line_s;
    logic [127:0]      work_data_s;
    logic              pend_valid_s;
    logic [LW-1:0]     pend_line_s;
    logic [127:0]      pend_data_s;
    logic              overflow_s;
    logic              busy_s;
    logic              sram_en_s;
    logic              sram_we_s;
    logic [MEM_AW-1:0] sram_addr_s;
    logic [31:0]       sram_wdata_s;
    logic [95:0]       rd_buf_s;
    logic [127:0]      resp_data_s;
    logic              resp_ready_s;

    logic [LW-1:0]     req_line_s;
    logic [1:0]        beat_inc_s;
    logic              wr_pulse_s;
    logic              rd_req_s;
    logic              drain_s;
    logic              unused_s;

    assign req_line_s = mem_req_i.addr[MEM_AW+1:4];
    assign beat_inc_s = beat_r + 2'd1;
    assign wr_pulse_s = mem_req_i.valid & mem_req_i.rw;
    assign rd_req_s   = mem_req_i.valid & ~mem_req_i.rw;
    // The buffer is emptied exactly when IDLE hands it to the WRITE sequence.
    assign drain_s    = (state_r == ST_IDLE) & pend_valid_r;
    // Offset bits and address bits beyond the SRAM range are intentionally dropped.
    assign unused_s   = ^{mem_req_i.addr[31:MEM_AW+2], mem_req_i.addr[3:0]};

    // Sequencer: next state plus the SRAM beat and response to present next cycle.
    always_comb begin
        state_s      = state_r;
        beat_s       = beat_r;
        work_line_s  = work_line_r;
        work_data_s  = work_data_r;
        rd_buf_s     = rd_buf_r;
        resp_data_s  = resp_data_r;
        resp_ready_s = 1'b0;
        sram_en_s    = 1'b0;
        sram_we_s    = 1'b0;
        sram_addr_s  = {MEM_AW{1'b0}};
        sram_wdata_s = 32'd0;

        case (state_r)
            ST_IDLE: begin
                if (pend_valid_r) begin
                    // Posted write has priority over a waiting read.
                    state_s      = ST_WRITE;
                    beat_s       = 2'd0;
                    work_line_s  = pend_line_r;
                    work_data_s  = pend_data_r;
                    sram_en_s    = 1'b1;
                    sram_we_s    = 1'b1;
                    sram_addr_s  = {pend_line_r, 2'd0};
                    sram_wdata_s = beat_word(pend_data_r, 2'd0);
                end else if (rd_req_s) begin
                    state_s     = ST_READ;
                    beat_s      = 2'd0;
                    work_line_s = req_line_s;
                    sram_en_s   = 1'b1;
                    sram_addr_s = {req_line_s, 2'd0};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (beat_r == 2'd3) begin
                    state_s = ST_IDLE;
                end else begin
                    beat_s       = beat_inc_s;
                    sram_en_s    = 1'b1;
                    sram_we_s    = 1'b1;
                    sram_addr_s  = {work_line_r, beat_inc_s};
                    sram_wdata_s = beat_word(work_data_r, beat_inc_s);
                end
            end
            ST_READ: begin
                // Read data lags its enable by one cycle, so beat k collects word k-1.
                case (beat_r)
                    2'd1:    rd_buf_s[31:0]  = sram_rdata_i;
                    2'd2:    rd_buf_s[63:32] = sram_rdata_i;
                    2'd3:    rd_buf_s[95:64] = sram_rdata_i;
                    default: rd_buf_s        = rd_buf_r;
                endcase
                if (beat_r == 2'd3) begin
                    state_s = ST_READ_TAIL;
                end else begin
                    beat_s      = beat_inc_s;
                    sram_en_s   = 1'b1;
                    sram_addr_s = {work_line_r, beat_inc_s};
                end
            end
            ST_READ_TAIL: begin
                state_s      = ST_RESP;
                resp_data_s  = {sram_rdata_i, rd_buf_r};
                resp_ready_s = 1'b1;
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Pending write buffer: capture in any state, drop and flag when full and not draining.
    always_comb begin
        pend_valid_s = pend_valid_r;
        pend_line_s  = pend_line_r;
        pend_data_s  = pend_data_r;
        overflow_s   = overflow_r;
        if (wr_pulse_s) begin
            if (!pend_valid_r || drain_s) begin
                pend_valid_s = 1'b1;
                pend_line_s  = req_line_s;
                pend_data_s  = mem_req_i.data;
            end else begin
                overflow_s = 1'b1;
            end
        end else if (drain_s) begin
            pend_valid_s = 1'b0;
        end else begin
            pend_valid_s = pend_valid_r;
        end
        busy_s = (state_s != ST_IDLE) | pend_valid_s;
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= ST_IDLE;
            beat_r       <= 2'd0;
            work_line_r  <= {LW{1'b0}};
            work_data_r  <= 128'd0;
            pend_valid_r <= 1'b0;
            pend_line_r  <= {LW{1'b0}};
            pend_data_r  <= 128'd0;
            overflow_r   <= 1'b0;
            busy_r       <= 1'b0;
            sram_en_r    <= 1'b0;
            sram_we_r    <= 1'b0;
            sram_addr_r  <= {MEM_AW{1'b0}};
            sram_wdata_r <= 32'd0;
            rd_buf_r     <= 96'd0;
            resp_data_r  <= 128'd0;
            resp_ready_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            beat_r       <= beat_s;
            work_line_r  <= work_line_s;
            work_data_r  <= work_data_s;
            pend_valid_r <= pend_valid_s;
            pend_line_r  <= pend_line_s;
            pend_data_r  <= pend_data_s;
            overflow_r   <= overflow_s;
            busy_r       <= busy_s;
            sram_en_r    <= sram_en_s;
            sram_we_r    <= sram_we_s;
            sram_addr_r  <= sram_addr_s;
            sram_wdata_r <= sram_wdata_s;
            rd_buf_r     <= rd_buf_s;
            resp_data_r  <= resp_data_s;
            resp_ready_r <= resp_ready_s;
        end
    end

    assign mem_data_o.data  = resp_data_r;
    assign mem_data_o.ready = resp_ready_r;
    assign sram_en_o        = sram_en_r;
    assign sram_we_o        = sram_we_r;
    assign sram_addr_o      = sram_addr_r;
    assign sram_wdata_o     = sram_wdata_r;
    assign busy_o           = busy_r;
    assign overflow_o       = overflow_r;

endmodule
